// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared write-back control encodings (destination select,
//                result select, load extension modes).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Destination register select
  localparam logic [1:0] c_dst_rt   = 2'b00;
  localparam logic [1:0] c_dst_rd   = 2'b01;
  localparam logic [1:0] c_dst_link = 2'b10;
  localparam logic [1:0] c_dst_none = 2'b11;

  // Write-back result select
  localparam logic [1:0] c_res_alu  = 2'b00;
  localparam logic [1:0] c_res_load = 2'b01;
  localparam logic [1:0] c_res_link = 2'b10;
  localparam logic [1:0] c_res_imm  = 2'b11;

  // Load extension modes; unlisted codes fall back to a full word
  localparam logic [2:0] c_ext_word = 3'b000;
  localparam logic [2:0] c_ext_lb   = 3'b001;
  localparam logic [2:0] c_ext_lbu  = 3'b010;
  localparam logic [2:0] c_ext_lh   = 3'b011;
  localparam logic [2:0] c_ext_lhu  = 3'b100;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Combinational load byte/halfword extraction and extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_ext
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [2:0]        ext_mode,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes; a misaligned halfword ignores offset[0]
  always_comb begin
    w_byte = word[{offset, 3'b000} +: 8];
    w_half = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (ext_mode)
      c_ext_lb:  data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      c_ext_lbu: data = {{(DATA_W-8){1'b0}}, w_byte};
      c_ext_lh:  data = {{(DATA_W-16){w_half[15]}}, w_half};
      c_ext_lhu: data = {{(DATA_W-16){1'b0}}, w_half};
      default:   data = word;
    endcase
  end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_select_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select_stage
//  Description : Registered write-back select stage (destination, result
//                mux, load extension) with stall hold and flush bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_select_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int LINK_OFS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [1:0]        reg_dst,
  input  logic [1:0]        mem_to_reg,
  input  logic [2:0]        ext_mode,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data
);

  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_link_data;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_we;

  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .word     (mem_dout),
    .offset   (alu_ans[1:0]),
    .ext_mode (ext_mode),
    .data     (w_load_data)
  );

  assign w_link_data = pc + DATA_W'(LINK_OFS);

  always_comb begin
    w_addr = '0;
    w_data = '0;
    if (in_valid) begin
      case (reg_dst)
        c_dst_rt:   w_addr = rt;
        c_dst_rd:   w_addr = rd;
        c_dst_link: w_addr = ADDR_W'(LINK_REG);
        default:    w_addr = '0;
      endcase
      case (mem_to_reg)
        c_res_alu:  w_data = alu_ans;
        c_res_load: w_data = w_load_data;
        c_res_link: w_data = w_link_data;
        default:    w_data = imm;
      endcase
    end
    // Register zero is hard-wired, so a write to it is suppressed
    w_we = in_valid && (reg_dst != c_dst_none) && (w_addr != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
    end
  end

  assign out_valid = r_valid;
  assign reg_we    = r_we;
  assign reg_addr  = r_addr;
  assign reg_data  = r_data;

endmodule : wb_select_stage
`default_nettype wire

// File: doc/wb_select_stage.md
WB_SELECT_STAGE -- requirements
Module: wb_select_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and write-back data width (multiple of 8, >=32).
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter LINK_REG, default 31, destination address for link writes.
REQ-004 SHALL have parameter LINK_OFS, default 4, offset added to pc for link data.
REQ-005 SHALL have ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  in_valid  in  1  upstream instruction valid
  stall  in  1  hold stage contents
  flush  in  1  kill incoming instruction, insert bubble
  rt  in  ADDR_W  rt field
  rd  in  ADDR_W  rd field
  reg_dst  in  2  00 rt, 01 rd, 10 LINK_REG, 11 no write
  mem_to_reg  in  2  00 alu_ans, 01 load data, 10 pc+LINK_OFS, 11 imm
  ext_mode  in  3  load extension: 000 word, 001 lb, 010 lbu, 011 lh, 100 lhu
  alu_ans  in  DATA_W  ALU result; bits [1:0] are load byte offset
  mem_dout  in  DATA_W  raw memory read word
  pc  in  DATA_W  instruction address
  imm  in  DATA_W  extended immediate (lui path)
  out_valid  out  1  registered instruction valid
  reg_we  out  1  register-file write enable
  reg_addr  out  ADDR_W  write address
  reg_data  out  DATA_W  write data

Function
REQ-006 SHALL register all selected outputs; latency 1 clk from input capture to outputs.
REQ-007 SHALL capture inputs on rising clk when stall=0 and flush=0; out_valid<=in_valid.
REQ-008 SHALL, when stall=1 and flush=0, hold every output unchanged.
REQ-009 SHALL, when flush=1 (any stall value), load a bubble: out_valid=0, reg_we=0, reg_addr=0, reg_data=0; flush has priority over stall.
REQ-010 SHALL drive reg_we=out_valid AND (reg_dst!=11) AND (reg_addr!=0).
REQ-011 SHALL select reg_addr per reg_dst; reg_dst=11 SHALL yield reg_addr=0.
REQ-012 SHALL compute link data as pc+LINK_OFS modulo 2^DATA_W (wrap, no carry out).
REQ-013 SHALL extract load byte at alu_ans[1:0] (little-endian), halfword at alu_ans[1]; lb/lh sign-extend, lbu/lhu zero-extend to DATA_W.
REQ-014 SHALL treat ext_mode 101-111 as word; misaligned halfword (alu_ans[0]=1) SHALL use alu_ans[1] only, no trap.
REQ-015 SHALL gate data capture: when in_valid=0 captured reg_data/reg_addr SHALL be 0.
REQ-016 SHALL contain no combinational path from any input to any output.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously clear out_valid, reg_we, reg_addr, reg_data to 0.
REQ-018 SHALL resume capture on the first rising clk after rst_n deasserts; reset mid-stall SHALL discard the held instruction.

Structure
REQ-019 SHALL place reg_dst codes, mem_to_reg codes and ext_mode codes as named constants in shared package cpu_ctrl_pkg.
REQ-020 SHALL implement load extraction/extension in combinational sub-module load_ext (inputs word, offset, ext_mode; output DATA_W).

Verification
REQ-021 ALU write: rd=8, reg_dst=01, mem_to_reg=00, alu_ans=0x1234_5678, in_valid=1 -> next clk reg_we=1, reg_addr=8, reg_data=0x1234_5678.
REQ-022 Load byte: mem_dout=0x80FF_7F01, alu_ans=0x...03, ext_mode=001 -> reg_data=0xFFFF_FF80; ext_mode=010 -> 0x0000_0080; ext_mode=011 -> 0xFFFF_80FF.
REQ-023 Link wrap: reg_dst=10, mem_to_reg=10, pc=0xFFFF_FFFC -> reg_addr=31, reg_data=0x0000_0000, reg_we=1.
REQ-024 Stall/flush: capture rd=5 data 0xA; stall=1 two clks with new inputs -> outputs stay 5/0xA; stall=1 and flush=1 -> out_valid=0, reg_we=0.
REQ-025 $0 and no-write: rt=0, reg_dst=00 -> reg_we=0; reg_dst=11 -> reg_we=0, reg_addr=0.
REQ-026 Reset: assert rst_n=0 mid-cycle with reg_we=1 -> all outputs 0 immediately, before next clk edge.
